one_hot_loop_controller: RTL

ONE_HOT_LOOP_CONTROLLER -- requirements
Module: one_hot_loop_controller

---
 rtl/one_hot_loop_controller.sv | 90 +++++++++
 1 files changed

// File: rtl/one_hot_loop_controller.sv
// One-hot loop controller: sequences LOAD / RUN / WAIT / DONE around a
// datapath, issuing count_len step strobes gated by dp_ready.
module one_hot_loop_controller #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] count_len,
    input  logic             dp_ready,
    output logic [4:0]       state,
    output logic             ld_en,
    output logic             step_en,
    output logic [CNT_W-1:0] remaining,
    output logic             busy,
    output logic             done,
    output logic             onehot_err
);

    localparam logic [4:0] StIdle = 5'b00001;
    localparam logic [4:0] StLoad = 5'b00010;
    localparam logic [4:0] StRun  = 5'b00100;
    localparam logic [4:0] StWait = 5'b01000;
    localparam logic [4:0] StDone = 5'b10000;

    logic [4:0]       state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             legal;

    assign legal     = $onehot(state_q);
    assign state     = state_q;
    assign remaining = rem_q;

    // State and iteration-count registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state and next-count logic; any non-one-hot vector recovers to IDLE.
    always_comb begin
        state_d = StIdle;
        rem_d   = rem_q;
        case (state_q)
            StIdle: state_d = start ? StLoad : StIdle;
            StLoad: begin
                rem_d   = count_len;
                state_d = (count_len == '0) ? StDone : StRun;
            end
            StRun: begin
                if (!dp_ready) begin
                    state_d = StWait;
                end else begin
                    // Guarded decrement so the count can never wrap below zero.
                    if (rem_q != '0) rem_d = rem_q - CNT_W'(1);
                    state_d = (rem_q <= CNT_W'(1)) ? StDone : StRun;
                end
            end
            StWait: state_d = dp_ready ? StRun : StWait;
            StDone: begin
                rem_d   = '0;
                state_d = StIdle;
            end
            default: begin
                rem_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Output decode; strobes are suppressed during reset and in illegal states.
    always_comb begin
        ld_en      = 1'b0;
        step_en    = 1'b0;
        done       = 1'b0;
        busy       = ~state_q[0];
        onehot_err = ~legal & ~rst;
        if (!rst && legal) begin
            ld_en   = (state_q == StLoad);
            step_en = (state_q == StRun) & dp_ready;
            done    = (state_q == StDone);
        end
    end

endmodule
